// File: rtl/ahb_arbiter_if.sv
// Bundle of the per-master AHB3-Lite ports and the shared slave-side bus around ahb_arbiter.
// The arbiter connects through the slave modport; the master modport is the masters/bus view.
interface ahb_arbiter_if #(
    parameter int MASTERS = 2
);
    logic [31:0] s_mhaddr_i      [MASTERS];
    logic [1:0]  s_mhtrans_i     [MASTERS];
    logic        s_mhwrite_i     [MASTERS];
    logic [2:0]  s_mhsize_i      [MASTERS];
    logic [3:0]  s_mhprot_i      [MASTERS];
    logic [31:0] s_mhwdata_i     [MASTERS];
    logic        s_mhready_o     [MASTERS];
    logic        s_mhresp_o      [MASTERS];
    logic [31:0] s_mhrdata_o     [MASTERS];
    logic [6:0]  s_mhrchecksum_o [MASTERS];

    logic [31:0] s_haddr_o;
    logic [1:0]  s_htrans_o;
    logic        s_hwrite_o;
    logic [2:0]  s_hsize_o;
    logic [3:0]  s_hprot_o;
    logic [31:0] s_hwdata_o;
    logic        s_hready_i;
    logic        s_hresp_i;
    logic [31:0] s_hrdata_i;
    logic [6:0]  s_hrchecksum_i;

    modport slave (
        input  s_mhaddr_i, s_mhtrans_i, s_mhwrite_i, s_mhsize_i, s_mhprot_i, s_mhwdata_i,
        output s_mhready_o, s_mhresp_o, s_mhrdata_o, s_mhrchecksum_o,
        output s_haddr_o, s_htrans_o, s_hwrite_o, s_hsize_o, s_hprot_o, s_hwdata_o,
        input  s_hready_i, s_hresp_i, s_hrdata_i, s_hrchecksum_i
    );

    modport master (
        output s_mhaddr_i, s_mhtrans_i, s_mhwrite_i, s_mhsize_i, s_mhprot_i, s_mhwdata_i,
        input  s_mhready_o, s_mhresp_o, s_mhrdata_o, s_mhrchecksum_o,
        input  s_haddr_o, s_htrans_o, s_hwrite_o, s_hsize_o, s_hprot_o, s_hwdata_o,
        output s_hready_i, s_hresp_i, s_hrdata_i, s_hrchecksum_i
    );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB3-Lite arbiter: muxes MASTERS masters onto one slave-side bus and parks a
// finished data-phase response per master until that master is granted again.
module ahb_arbiter #(
    parameter int MASTERS = 2
) (
    input logic          s_clk_i,
    input logic          s_reset_i,
    ahb_arbiter_if.slave bus
);
    localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    logic [MASTERS-1:0] req;
    logic [MASTERS-1:0] mready;
    logic [IW-1:0]      grant;
    logic               grant_valid;

    logic [IW-1:0]      last_reg;
    logic [IW-1:0]      data_owner_reg;
    logic               data_active_reg;

    for (genvar gi = 0; gi < MASTERS; gi++) begin : g_req
        assign req[gi] = bus.s_mhtrans_i[gi][1];
    end

    // Rotating search starting just after the last winner; a SEQ burst keeps the bus.
    always_comb begin
        logic [IW:0] cand;
        logic        found;
        grant       = '0;
        found       = 1'b0;
        cand        = '0;
        grant_valid = |req;
        for (int off = 0; off < MASTERS; off++) begin
            cand = {1'b0, last_reg} + (IW+1)'(1) + (IW+1)'(off);
            if (cand >= (IW+1)'(MASTERS)) begin
                cand = cand - (IW+1)'(MASTERS);
            end
            if (!found && req[cand[IW-1:0]]) begin
                grant = cand[IW-1:0];
                found = 1'b1;
            end
        end
        if (data_active_reg && (bus.s_mhtrans_i[data_owner_reg] == 2'b11)) begin
            grant = data_owner_reg;
        end
    end

    always_comb begin
        bus.s_haddr_o  = '0;
        bus.s_htrans_o = 2'b00;
        bus.s_hwrite_o = 1'b0;
        bus.s_hsize_o  = '0;
        bus.s_hprot_o  = '0;
        if (grant_valid) begin
            bus.s_haddr_o  = bus.s_mhaddr_i[grant];
            bus.s_htrans_o = bus.s_mhtrans_i[grant];
            bus.s_hwrite_o = bus.s_mhwrite_i[grant];
            bus.s_hsize_o  = bus.s_mhsize_i[grant];
            bus.s_hprot_o  = bus.s_mhprot_i[grant];
        end
    end

    assign bus.s_hwdata_o = bus.s_mhwdata_i[data_owner_reg];

    // Arbitration state only advances when the slave completes the current phase.
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            last_reg        <= IW'(MASTERS - 1);
            data_owner_reg  <= '0;
            data_active_reg <= 1'b0;
        end else if (bus.s_hready_i) begin
            if (grant_valid) begin
                last_reg <= grant;
            end
            data_owner_reg  <= grant;
            data_active_reg <= grant_valid;
        end
    end

    for (genvar gi = 0; gi < MASTERS; gi++) begin : g_master
        logic        pend_valid_reg;
        logic [31:0] pend_rdata_reg;
        logic        pend_resp_reg;
        logic [6:0]  pend_chk_reg;
        logic        capture;
        logic        owns_data;

        assign mready[gi] = bus.s_hready_i &
                            (~req[gi] | (grant_valid & (grant == IW'(gi))));
        assign bus.s_mhready_o[gi] = mready[gi];

        assign owns_data = data_active_reg & (data_owner_reg == IW'(gi));
        // Owner finishes its data phase but has lost the next address phase: park the response.
        assign capture   = owns_data & bus.s_hready_i & req[gi] & (grant != IW'(gi));

        always_ff @(posedge s_clk_i) begin
            if (s_reset_i) begin
                pend_valid_reg <= 1'b0;
            end else if (capture) begin
                pend_valid_reg <= 1'b1;
            end else if (mready[gi]) begin
                pend_valid_reg <= 1'b0;
            end
        end

        always_ff @(posedge s_clk_i) begin
            if (capture) begin
                pend_rdata_reg <= bus.s_hrdata_i;
                pend_resp_reg  <= bus.s_hresp_i;
                pend_chk_reg   <= bus.s_hrchecksum_i;
            end
        end

        always_comb begin
            bus.s_mhrdata_o[gi]     = '0;
            bus.s_mhresp_o[gi]      = 1'b0;
            bus.s_mhrchecksum_o[gi] = '0;
            if (pend_valid_reg) begin
                bus.s_mhrdata_o[gi]     = pend_rdata_reg;
                bus.s_mhresp_o[gi]      = pend_resp_reg;
                bus.s_mhrchecksum_o[gi] = pend_chk_reg;
            end else if (owns_data) begin
                bus.s_mhrdata_o[gi]     = bus.s_hrdata_i;
                bus.s_mhresp_o[gi]      = bus.s_hresp_i;
                bus.s_mhrchecksum_o[gi] = bus.s_hrchecksum_i;
            end
        end
    end
endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: directed scenarios plus random traffic, with expected per-cycle
// outputs queued by the stimulus side and compared by an independent negedge monitor.
module tb_ahb_arbiter;
    localparam int M = 3;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    ahb_arbiter_if #(.MASTERS(M)) bus ();

    ahb_arbiter #(.MASTERS(M)) dut (
        .s_clk_i   (clk),
        .s_reset_i (srst),
        .bus       (bus)
    );

    typedef struct packed {
        logic [41:0]         aph;
        logic [31:0]         wd;
        logic [M-1:0][40:0]  rsp;
    } snap_t;

    typedef struct packed {
        logic [2:0]  kind;
        logic [3:0]  idx;
        logic [31:0] val;
    } spot_t;

    snap_t sb_q[$];
    spot_t spot_q[$];
    snap_t exp_s;
    int    total = 0;
    int    bad   = 0;

    // Reference model state: who spoke last, who owns the data phase, parked responses.
    int          m_last;
    int          m_owner;
    bit          m_active;
    bit          pv    [M];
    logic [31:0] prd   [M];
    logic        presp [M];
    logic [6:0]  pchk  [M];
    int          cur_g;
    bit          cur_gv;
    bit          cur_req [M];
    bit          cur_rdy [M];

    task automatic compute();
        cur_gv = 1'b0;
        cur_g  = 0;
        for (int m = 0; m < M; m++) cur_req[m] = bus.s_mhtrans_i[m][1];
        for (int k = 1; k <= M; k++) begin
            int c = (m_last + k) % M;
            if (!cur_gv && cur_req[c]) begin
                cur_gv = 1'b1;
                cur_g  = c;
            end
        end
        if (m_active && bus.s_mhtrans_i[m_owner] == 2'b11) cur_g = m_owner;
        exp_s.aph = cur_gv ? {bus.s_mhaddr_i[cur_g], bus.s_mhtrans_i[cur_g], bus.s_mhwrite_i[cur_g],
                              bus.s_mhsize_i[cur_g], bus.s_mhprot_i[cur_g]} : 42'h0;
        exp_s.wd = bus.s_mhwdata_i[m_owner];
        for (int m = 0; m < M; m++) begin
            cur_rdy[m] = bus.s_hready_i && (!cur_req[m] || (cur_gv && cur_g == m));
            if (pv[m])
                exp_s.rsp[m] = {cur_rdy[m], presp[m], prd[m], pchk[m]};
            else if (m_active && m_owner == m)
                exp_s.rsp[m] = {cur_rdy[m], bus.s_hresp_i, bus.s_hrdata_i, bus.s_hrchecksum_i};
            else
                exp_s.rsp[m] = {cur_rdy[m], 1'b0, 32'h0, 7'h0};
        end
    endtask

    task automatic update();
        if (srst) begin
            m_last   = M - 1;
            m_owner  = 0;
            m_active = 1'b0;
            for (int m = 0; m < M; m++) pv[m] = 1'b0;
        end else if (bus.s_hready_i) begin
            for (int m = 0; m < M; m++) begin
                if (m_active && m_owner == m && cur_req[m] && cur_g != m) begin
                    pv[m]    = 1'b1;
                    prd[m]   = bus.s_hrdata_i;
                    presp[m] = bus.s_hresp_i;
                    pchk[m]  = bus.s_hrchecksum_i;
                end else if (cur_rdy[m]) begin
                    pv[m] = 1'b0;
                end
            end
            if (cur_gv) m_last = cur_g;
            m_owner  = cur_g;
            m_active = cur_gv;
        end
    endtask

    task automatic step(input bit check);
        compute();
        if (check) sb_q.push_back(exp_s);
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic spot(input logic [2:0] kind, input logic [3:0] idx, input logic [31:0] val);
        spot_t p;
        p.kind = kind;
        p.idx  = idx;
        p.val  = val;
        spot_q.push_back(p);
    endtask

    task automatic drv_m(input int m, input logic [1:0] t, input logic [31:0] a,
                         input logic w, input logic [31:0] wd);
        bus.s_mhtrans_i[m] = t;
        bus.s_mhaddr_i[m]  = a;
        bus.s_mhwrite_i[m] = w;
        bus.s_mhsize_i[m]  = 3'd2;
        bus.s_mhprot_i[m]  = 4'h3;
        bus.s_mhwdata_i[m] = wd;
    endtask

    task automatic drv_s(input logic rdy, input logic rs, input logic [31:0] rd, input logic [6:0] ck);
        bus.s_hready_i     = rdy;
        bus.s_hresp_i      = rs;
        bus.s_hrdata_i     = rd;
        bus.s_hrchecksum_i = ck;
    endtask

    task automatic idle_all();
        for (int m = 0; m < M; m++) drv_m(m, 2'b00, 32'h0, 1'b0, 32'h0);
    endtask

    function automatic string spot_name(input logic [2:0] k);
        case (k)
            3'd0:    return "htrans";
            3'd1:    return "haddr";
            3'd2:    return "mhready";
            3'd3:    return "mhrdata";
            3'd4:    return "mhresp";
            default: return "hwdata";
        endcase
    endfunction

    // Monitor: drains everything queued for the current cycle, away from the active edge.
    always @(negedge clk) begin
        snap_t       s;
        spot_t       p;
        logic [41:0] act_aph;
        logic [40:0] act_rsp;
        logic [31:0] act;
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            act_aph = {bus.s_haddr_o, bus.s_htrans_o, bus.s_hwrite_o, bus.s_hsize_o, bus.s_hprot_o};
            total++;
            if (act_aph !== s.aph) begin
                bad++;
                $display("FAIL addr_phase t=%0t got=%h exp=%h", $time, act_aph, s.aph);
            end
            total++;
            if (bus.s_hwdata_o !== s.wd) begin
                bad++;
                $display("FAIL hwdata t=%0t got=%h exp=%h", $time, bus.s_hwdata_o, s.wd);
            end
            for (int m = 0; m < M; m++) begin
                act_rsp = {bus.s_mhready_o[m], bus.s_mhresp_o[m], bus.s_mhrdata_o[m], bus.s_mhrchecksum_o[m]};
                total++;
                if (act_rsp !== s.rsp[m]) begin
                    bad++;
                    $display("FAIL resp_m%0d t=%0t got=%h exp=%h (ready,resp,rdata,chk)",
                             m, $time, act_rsp, s.rsp[m]);
                end
            end
            if (s.aph[9] && bus.s_hready_i)
                $display("xfer t=%0t haddr=%h htrans=%0d hwrite=%0b", $time, s.aph[41:10], s.aph[9:8], s.aph[7]);
        end
        while (spot_q.size() > 0) begin
            p = spot_q.pop_front();
            case (p.kind)
                3'd0:    act = 32'(bus.s_htrans_o);
                3'd1:    act = bus.s_haddr_o;
                3'd2:    act = 32'(bus.s_mhready_o[p.idx]);
                3'd3:    act = bus.s_mhrdata_o[p.idx];
                3'd4:    act = 32'(bus.s_mhresp_o[p.idx]);
                default: act = bus.s_hwdata_o;
            endcase
            total++;
            if (act !== p.val) begin
                bad++;
                $display("FAIL %s[%0d] t=%0t got=%h exp=%h", spot_name(p.kind), p.idx, $time, act, p.val);
            end
        end
    end

    initial begin
        srst = 1'b1;
        idle_all();
        drv_s(1'b1, 1'b0, 32'h0, 7'h0);
        step(0);
        step(0);
        srst = 1'b0;

        // Single uncontended read after reset.
        drv_m(0, 2'b10, 32'h100, 1'b0, 32'h0);
        drv_s(1'b1, 1'b0, 32'hDEADBEEF, 7'h12);
        spot(3'd0, 4'd0, 32'd2);
        spot(3'd1, 4'd0, 32'h100);
        spot(3'd2, 4'd0, 32'd1);
        step(1);
        idle_all();
        spot(3'd3, 4'd0, 32'hDEADBEEF);
        step(1);

        // Two continuous requesters alternate from reset.
        srst = 1'b1;
        step(1);
        srst = 1'b0;
        drv_m(0, 2'b10, 32'hA0, 1'b0, 32'h0);
        drv_m(1, 2'b10, 32'hB0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            spot(3'd1, 4'd0, (k % 2 == 1) ? 32'hB0 : 32'hA0);
            spot(3'd2, (k % 2 == 1) ? 4'd0 : 4'd1, 32'd0);
            step(1);
        end
        idle_all();
        step(1);

        // m0 loses the bus right after its read: response parked then delivered.
        drv_m(0, 2'b10, 32'h10, 1'b0, 32'h0);
        step(1);
        drv_m(0, 2'b10, 32'h14, 1'b0, 32'h0);
        drv_m(1, 2'b10, 32'hB4, 1'b0, 32'h0);
        drv_s(1'b1, 1'b0, 32'h11, 7'h05);
        spot(3'd2, 4'd0, 32'd0);
        spot(3'd3, 4'd0, 32'h11);
        step(1);
        drv_m(1, 2'b00, 32'h0, 1'b0, 32'h0);
        drv_s(1'b1, 1'b0, 32'h99, 7'h00);
        spot(3'd2, 4'd0, 32'd1);
        spot(3'd3, 4'd0, 32'h11);
        spot(3'd1, 4'd0, 32'h14);
        step(1);

        // m1 write stretched by three slave wait states.
        drv_m(0, 2'b00, 32'h0, 1'b0, 32'h0);
        drv_m(1, 2'b10, 32'h200, 1'b1, 32'h0);
        drv_s(1'b1, 1'b0, 32'h0, 7'h0);
        spot(3'd1, 4'd0, 32'h200);
        step(1);
        drv_m(1, 2'b00, 32'h0, 1'b0, 32'hCAFE0001);
        drv_m(0, 2'b10, 32'h300, 1'b0, 32'h0);
        drv_s(1'b0, 1'b0, 32'h0, 7'h0);
        for (int k = 0; k < 3; k++) begin
            spot(3'd5, 4'd0, 32'hCAFE0001);
            spot(3'd2, 4'd0, 32'd0);
            spot(3'd2, 4'd1, 32'd0);
            step(1);
        end
        drv_s(1'b1, 1'b0, 32'h0, 7'h0);
        drv_m(1, 2'b10, 32'h204, 1'b1, 32'hCAFE0001);
        spot(3'd1, 4'd0, 32'h300);
        spot(3'd5, 4'd0, 32'hCAFE0001);
        step(1);

        // Two-cycle ERROR on an m1 read.
        drv_m(0, 2'b00, 32'h0, 1'b0, 32'h0);
        drv_m(1, 2'b10, 32'h400, 1'b0, 32'h0);
        step(1);
        drv_m(1, 2'b00, 32'h0, 1'b0, 32'h0);
        drv_s(1'b0, 1'b1, 32'h0, 7'h0);
        spot(3'd4, 4'd1, 32'd1);
        spot(3'd2, 4'd1, 32'd0);
        step(1);
        drv_s(1'b1, 1'b1, 32'h0, 7'h0);
        spot(3'd4, 4'd1, 32'd1);
        spot(3'd2, 4'd1, 32'd1);
        step(1);
        drv_s(1'b1, 1'b0, 32'h0, 7'h0);

        // Reset while m0 has a parked response.
        drv_m(0, 2'b10, 32'h500, 1'b0, 32'h0);
        step(1);
        drv_m(0, 2'b10, 32'h504, 1'b0, 32'h0);
        drv_m(1, 2'b10, 32'h600, 1'b0, 32'h0);
        drv_s(1'b1, 1'b0, 32'h55, 7'h0);
        step(1);
        idle_all();
        drv_s(1'b1, 1'b0, 32'h0, 7'h0);
        srst = 1'b1;
        spot(3'd0, 4'd0, 32'd0);
        spot(3'd3, 4'd0, 32'h55);
        step(1);
        srst = 1'b0;
        spot(3'd3, 4'd0, 32'h0);
        spot(3'd0, 4'd0, 32'd0);
        step(1);
        drv_m(0, 2'b10, 32'h700, 1'b0, 32'h0);
        drv_m(1, 2'b10, 32'h800, 1'b0, 32'h0);
        spot(3'd1, 4'd0, 32'h700);
        step(1);
        idle_all();
        step(1);

        // Random traffic, including SEQ locks, wait states, errors and stray resets.
        for (int i = 0; i < 600; i++) begin
            for (int m = 0; m < M; m++) begin
                drv_m(m, 2'($urandom_range(0, 3)), $urandom, 1'($urandom), $urandom);
                bus.s_mhsize_i[m] = 3'($urandom);
                bus.s_mhprot_i[m] = 4'($urandom);
            end
            drv_s(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), $urandom, 7'($urandom));
            srst = ($urandom_range(0, 60) == 0);
            step(1);
        end
        srst = 1'b0;
        idle_all();
        step(1);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
